// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts one command
// byte out on device clock edges with odd parity, checks the device ACK and times out stalled transfers.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES     = 5000,
  parameter int FIRST_EDGE_TIMEOUT = 750000,
  parameter int BIT_TIMEOUT        = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_A = (FIRST_EDGE_TIMEOUT > BIT_TIMEOUT) ? FIRST_EDGE_TIMEOUT : BIT_TIMEOUT;
  localparam int MAX_T = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
  localparam int CNT_W = ($clog2(MAX_T + 1) > 20) ? $clog2(MAX_T + 1) : 20;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, WAIT_FIRST, SHIFT, ACK, WAIT_IDLE, ERROR
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;

  logic clk_sync_p0, clk_sync_p1, clk_prev_p2;
  logic data_sync_p0, data_sync_p1;
  logic fe;
  logic fail;

  // Synchronizer stages; the idle bus level is high, so reset to 1 to avoid a false edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      clk_prev_p2  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= ps2_clk_in;
      clk_sync_p1  <= clk_sync_p0;
      clk_prev_p2  <= clk_sync_p1;
      data_sync_p0 <= ps2_data_in;
      data_sync_p1 <= data_sync_p0;
    end
  end

  assign fe = clk_prev_p2 & ~clk_sync_p1;

  always_comb begin
    fail = 1'b0;
    case (state)
      WAIT_FIRST:      fail = ~fe & (cnt == FIRST_LAST);
      SHIFT, WAIT_IDLE: fail = ~fe & (cnt == BIT_LAST);
      ACK:             fail = fe ? data_sync_p1 : (cnt == BIT_LAST);
      default:         fail = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      data_q      <= '0;
      cnt         <= '0;
      bit_idx     <= '0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (state != IDLE) cnt <= sat_inc(cnt);
      if (fail) begin
        state       <= ERROR;
        tx_error    <= 1'b1;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (tx_valid && tx_ready) begin
            data_q      <= tx_data;
            cnt         <= '0;
            bit_idx     <= '0;
            state       <= INHIBIT;
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
          end
          INHIBIT: if (cnt == INH_LAST) begin
            state       <= RTS;
            ps2_data_oe <= 1'b1;
          end
          RTS: begin
            state      <= WAIT_FIRST;
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
          end
          WAIT_FIRST: if (fe) begin
            ps2_data_oe <= ~data_q[0];
            bit_idx     <= 4'd1;
            cnt         <= '0;
            state       <= SHIFT;
          end
          // Data pulls low for a 0 bit; index 9 is the stop bit, so the line is released
          SHIFT: if (fe) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd9) begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end else if (bit_idx == 4'd8) begin
              ps2_data_oe <= ~odd_parity(data_q);
            end else begin
              ps2_data_oe <= ~data_q[bit_idx[2:0]];
            end
          end
          ACK: if (fe) begin
            cnt   <= '0;
            state <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            if (fe) cnt <= '0;
            if (clk_sync_p1 && data_sync_p1) begin
              tx_done  <= 1'b1;
              state    <= IDLE;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
          ERROR: begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a 40-cycle device clock model; device-sampled
// bits go to a queue and are matched against frames expected by the stimulus.
module tb_ps2_host_tx;
  localparam int INH      = 10;
  localparam int BIT_TO   = 200;
  localparam int FIRST_TO = 400;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk = 1'b1, dev_data = 1'b1;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, err_cnt = 0, done_early = 0;
  int cyc = 0, last_fall_cyc = 0;
  logic exp_q[$];
  logic obs_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Open-drain wired-AND of host pull-downs and the device model
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .FIRST_EDGE_TIMEOUT(FIRST_TO), .BIT_TIMEOUT(BIT_TO)
  ) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always begin
    @(posedge clock);
    #1;
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && !(ps2_clk_in && ps2_data_in)) done_early++;
  end

  task automatic start_tx(input logic [7:0] b, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) exp_q.push_back(fr[i]);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy && !ps2_clk_oe && !ps2_data_in) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  // Device samples data mid-high-phase, then clocks low; ACK is driven after the stop sample
  task automatic run_device(input int n_falls, input bit ack_low);
    for (int k = 0; k < n_falls; k++) begin
      repeat (10) @(negedge clock);
      obs_q.push_back(ps2_data_in);
      if (k == 10 && ack_low) dev_data = 1'b0;
      repeat (10) @(negedge clock);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (20) @(negedge clock);
      dev_clk = 1'b1;
    end
    repeat (10) @(negedge clock);
    dev_data = 1'b1;
  endtask

  task automatic test_reset;
    int hi, dhi;
    logic last_d;
    for (int i = 0; i < 8; i++) begin
      dev_clk  = i[0];
      dev_data = i[1];
      tx_valid = 1'b1;
      tx_data  = 8'hED;
      @(negedge clock);
      vectors++;
      if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_error} !== 6'b001000) begin
        miscompares++;
        $display("FAIL reset_outputs: got %b expected 001000", {ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_error});
      end
    end
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (tx_ready !== 1'b1 || done_cnt != 0 || err_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b done=%0d err=%0d expected 1,0,0", tx_ready, done_cnt, err_cnt);
    end
    exp_q.delete();
    obs_q.delete();
    start_tx(8'hED, 11);
    hi = 0; dhi = 0; last_d = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ps2_clk_oe) begin
        hi++;
        if (ps2_data_oe) dhi++;
        last_d = ps2_data_oe;
      end else if (hi > 0) break;
      @(negedge clock);
    end
    vectors++;
    if (hi != INH + 1) begin
      miscompares++;
      $display("FAIL inhibit_len: got %0d cycles expected %0d", hi, INH + 1);
    end
    vectors++;
    if (dhi != 1 || last_d !== 1'b1) begin
      miscompares++;
      $display("FAIL rts_data_oe: got %0d cycles last=%b expected 1 cycle last=1", dhi, last_d);
    end
    run_device(11, 1'b1);
    for (int i = 0; i < 60 && done_cnt == 0; i++) @(negedge clock);
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL reset_first_done: got %0d pulses expected 1", done_cnt);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_ack;
    int d0, e0;
    bit ok;
    logic e, o;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED, 11);
    vectors++;
    if (busy !== 1'b1 || tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL accept: busy=%b ready=%b clk_oe=%b expected 1,0,1", busy, tx_ready, ps2_clk_oe);
    end
    wait_release(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ack_release: got no release expected release within 200 cycles");
    end
    run_device(11, 1'b1);
    for (int i = 0; i < 60 && done_cnt == d0; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL ack_bit%0d: got %b expected %b", i, o, e);
      end
    end
    vectors++;
    if (done_cnt != d0 + 1 || err_cnt != e0 || done_early != 0) begin
      miscompares++;
      $display("FAIL ack_pulses: done=%0d err=%0d early=%0d expected %0d,%0d,0", done_cnt - d0, err_cnt - e0, done_early, 1, 0);
    end
    vectors++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || {ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      miscompares++;
      $display("FAIL ack_idle: ready=%b busy=%b oe=%b%b expected 1,0,00", tx_ready, busy, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_nack;
    int d0, e0;
    bit ok;
    logic e, o;
    d0 = done_cnt; e0 = err_cnt;
    exp_q.delete(); obs_q.delete();
    start_tx(8'h00, 11);
    wait_release(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL nack_release: got no release expected release within 200 cycles");
    end
    run_device(11, 1'b0);
    for (int i = 0; i < 60 && err_cnt == e0; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL nack_bit%0d: got %b expected %b", i, o, e);
      end
    end
    vectors++;
    if (err_cnt != e0 + 1 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL nack_pulses: err=%0d done=%0d expected 1,0", err_cnt - e0, done_cnt - d0);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL nack_idle: oe=%b%b ready=%b expected 00,1", ps2_clk_oe, ps2_data_oe, tx_ready);
    end
  endtask

  task automatic test_first_timeout;
    int e0, t0, dt;
    bit ok;
    e0 = err_cnt;
    exp_q.delete(); obs_q.delete();
    start_tx(8'hFF, 0);
    wait_release(ok);
    t0 = cyc;
    dt = -1;
    for (int i = 0; i < 600; i++) begin
      if (tx_error) begin
        dt = cyc - t0;
        break;
      end
      @(negedge clock);
    end
    vectors++;
    if (!ok || dt != FIRST_TO) begin
      miscompares++;
      $display("FAIL first_timeout: got %0d cycles expected %0d", dt, FIRST_TO);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      miscompares++;
      $display("FAIL first_timeout_release: oe=%b%b expected 00", ps2_clk_oe, ps2_data_oe);
    end
    repeat (3) @(negedge clock);
    vectors++;
    if (err_cnt != e0 + 1 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL first_timeout_pulse: err=%0d ready=%b expected 1,1", err_cnt - e0, tx_ready);
    end
  endtask

  task automatic test_bit_timeout;
    int e0, dt;
    bit ok;
    logic e, o;
    e0 = err_cnt;
    exp_q.delete(); obs_q.delete();
    start_tx(8'h5A, 4);
    wait_release(ok);
    run_device(4, 1'b1);
    dt = -1;
    for (int i = 0; i < 400; i++) begin
      if (tx_error) begin
        dt = cyc - last_fall_cyc;
        break;
      end
      @(negedge clock);
    end
    // Pin fall reaches the FSM on the 3rd edge (2 sync + edge register)
    vectors++;
    if (!ok || dt != BIT_TO + 3) begin
      miscompares++;
      $display("FAIL bit_timeout: got %0d cycles from pin fall expected %0d", dt, BIT_TO + 3);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL stall_bit%0d: got %b expected %b", i, o, e);
      end
    end
    repeat (3) @(negedge clock);
    vectors++;
    if (err_cnt != e0 + 1 || {ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      miscompares++;
      $display("FAIL bit_timeout_pulse: err=%0d oe=%b%b expected 1,00", err_cnt - e0, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    bit ok;
    logic e, o;
    d0 = done_cnt; e0 = err_cnt;
    exp_q.delete(); obs_q.delete();
    start_tx(8'hFF, 0);
    repeat (3) @(negedge clock);
    vectors++;
    if (ps2_clk_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL inhibit_active: clk_oe=%b expected 1", ps2_clk_oe);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset_inhibit: oe/busy=%b expected 000", {ps2_clk_oe, ps2_data_oe, busy});
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    start_tx(8'hFF, 6);
    wait_release(ok);
    run_device(5, 1'b1);
    vectors++;
    if (!ok || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL shift_busy: ok=%b busy=%b expected 1,1", ok, busy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL async_reset_shift: got %b expected 0010", {ps2_clk_oe, ps2_data_oe, tx_ready, busy});
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    vectors++;
    if (done_cnt != d0 || err_cnt != e0) begin
      miscompares++;
      $display("FAIL reset_no_pulse: done=%0d err=%0d expected 0,0", done_cnt - d0, err_cnt - e0);
    end
    exp_q.delete(); obs_q.delete();
    start_tx(8'hFF, 11);
    wait_release(ok);
    run_device(11, 1'b1);
    for (int i = 0; i < 60 && done_cnt == d0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL ff_bit%0d: got %b expected %b", i, o, e);
      end
    end
    vectors++;
    if (!ok || done_cnt != d0 + 1 || err_cnt != e0) begin
      miscompares++;
      $display("FAIL after_reset_done: done=%0d err=%0d expected 1,0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ack();
    test_nack();
    test_first_timeout();
    test_bit_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
